// File: rtl/stack_pkg.sv
// stack_pkg: shared state encoding, default sizes and occupancy-to-state helper for the stack unit
package stack_pkg;

    typedef enum logic [1:0] {S_EMPTY, S_PART, S_FULL} stack_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    function automatic stack_state_t state_of(input int unsigned n, input int unsigned depth);
        return n == 0 ? S_EMPTY : n == depth ? S_FULL : S_PART;
    endfunction

endpackage

// File: rtl/param_stack_unit_if.sv
// param_stack_unit_if: stack command/status bundle; STACK_HWM_EN adds the high-water-mark signal
interface param_stack_unit_if #(
    parameter int WIDTH = stack_pkg::DEF_WIDTH,
    parameter int DEPTH = stack_pkg::DEF_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
);

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

`ifdef STACK_HWM_EN
    logic [CW-1:0]    hwm;

    modport master (
        output push, pop, din, clr_err,
        input  tos, nos, count, empty, full, overflow, underflow, hwm
    );

    modport slave (
        input  push, pop, din, clr_err,
        output tos, nos, count, empty, full, overflow, underflow, hwm
    );
`else
    modport master (
        output push, pop, din, clr_err,
        input  tos, nos, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, din, clr_err,
        output tos, nos, count, empty, full, overflow, underflow
    );
`endif

endinterface

// File: rtl/stack_regfile.sv
// stack_regfile: entry storage with one synchronous write port and two asynchronous read ports
module stack_regfile
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1
);

    logic [WIDTH-1:0] mem [DEPTH];

    // single write port; storage is never cleared, occupancy decides what is visible
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/param_stack_unit.sv
// param_stack_unit: LIFO stack with tos/nos peek, replace-on-push+pop and sticky errors; STACK_HWM_EN adds hwm
module param_stack_unit
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input logic clk,
    input logic rst,
    param_stack_unit_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    stack_state_t     state;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_n;
    logic             empty_r;
    logic             full_r;
    logic             ovf_r;
    logic             udf_r;
    logic             inc;
    logic             dec;
    logic             we;
    logic             ovf_evt;
    logic             udf_evt;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    top_addr;
    logic [AW-1:0]    below_addr;
    logic [WIDTH-1:0] top_data;
    logic [WIDTH-1:0] below_data;

    assign top_addr   = AW'(count - CW'(1));
    assign below_addr = AW'(count - CW'(2));

    // push+pop on a non-empty stack overwrites the top; on an empty stack it degrades to a plain push
    always_comb begin
        inc     = bus.push && (bus.pop ? state == S_EMPTY : state != S_FULL);
        dec     = bus.pop && !bus.push && state != S_EMPTY;
        ovf_evt = bus.push && !bus.pop && state == S_FULL;
        udf_evt = bus.pop && !bus.push && state == S_EMPTY;
        we      = bus.push && !ovf_evt;
        waddr   = (bus.pop && state != S_EMPTY) ? top_addr : AW'(count);
        count_n = inc ? count + CW'(1) : dec ? count - CW'(1) : count;
    end

    // state, occupancy and sticky flags advance together; an error event outranks clr_err
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_EMPTY;
            count   <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
            udf_r   <= 1'b0;
        end else begin
            state   <= state_of(32'(count_n), 32'(FULL_CNT));
            count   <= count_n;
            empty_r <= count_n == '0;
            full_r  <= count_n == FULL_CNT;
            ovf_r   <= ovf_evt || (ovf_r && !bus.clr_err);
            udf_r   <= udf_evt || (udf_r && !bus.clr_err);
        end
    end

`ifdef STACK_HWM_EN
    logic [CW-1:0] hwm;

    // high-water mark tracks the peak occupancy; only reset clears it
    always_ff @(posedge clk) begin
        hwm <= rst ? '0 : (count_n > hwm ? count_n : hwm);
    end

    assign bus.hwm = hwm;
`endif

    stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_regfile (
        .clk    (clk),
        .we     (we),
        .waddr  (waddr),
        .wdata  (bus.din),
        .raddr0 (top_addr),
        .raddr1 (below_addr),
        .rdata0 (top_data),
        .rdata1 (below_data)
    );

    assign bus.tos       = count == '0 ? '0 : top_data;
    assign bus.nos       = count < CW'(2) ? '0 : below_data;
    assign bus.count     = count;
    assign bus.empty     = empty_r;
    assign bus.full      = full_r;
    assign bus.overflow  = ovf_r;
    assign bus.underflow = udf_r;

endmodule

// File: tb/tb_param_stack_unit.sv
// tb_param_stack_unit: directed + random stimulus against a queue-based stack model with a scoreboard monitor
module tb_param_stack_unit;

    localparam int W = 8;
    localparam int D = 16;
    localparam int C = $clog2(D) + 1;

    typedef struct {
        logic [W-1:0] tos;
        logic [W-1:0] nos;
        logic [C-1:0] count;
        logic         empty;
        logic         full;
        logic         ovf;
        logic         udf;
        logic [C-1:0] hwm;
    } exp_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    exp_t exp_q[$];
    exp_t mon_e;
    int   stk[$];
    bit   m_ovf;
    bit   m_udf;
    int   m_hwm;

    param_stack_unit_if #(.WIDTH(W), .DEPTH(D)) bus ();

    param_stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, a, x, $time);
        end
    endtask

    // one clock of stimulus; the model applies the same operation and queues the post-edge view
    task automatic op(input bit p, input bit q, input logic [W-1:0] d, input bit c, input bit r);
        exp_t e;
        bit is_e;
        bit is_f;
        @(negedge clk);
        rst = r;
        bus.push = p;
        bus.pop = q;
        bus.din = d;
        bus.clr_err = c;
        if (r) begin
            stk.delete();
            m_ovf = 0;
            m_udf = 0;
            m_hwm = 0;
        end else begin
            is_e = stk.size() == 0;
            is_f = stk.size() == D;
            if (c) begin
                m_ovf = 0;
                m_udf = 0;
            end
            if (p && q) begin
                if (is_e) stk.push_back(int'(d));
                else stk[$] = int'(d);
            end else if (p) begin
                if (is_f) m_ovf = 1;
                else stk.push_back(int'(d));
            end else if (q) begin
                if (is_e) m_udf = 1;
                else void'(stk.pop_back());
            end
            if (stk.size() > m_hwm) m_hwm = stk.size();
        end
        e.tos   = stk.size() > 0 ? W'(stk[$]) : '0;
        e.nos   = stk.size() > 1 ? W'(stk[$-1]) : '0;
        e.count = C'(stk.size());
        e.empty = stk.size() == 0;
        e.full  = stk.size() == D;
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        e.hwm   = C'(m_hwm);
        exp_q.push_back(e);
    endtask

    // monitor: the DUT shows a new result after every edge; compare it with the oldest queued expectation
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("tos", 64'(bus.tos), 64'(mon_e.tos));
            chk("nos", 64'(bus.nos), 64'(mon_e.nos));
            chk("count", 64'(bus.count), 64'(mon_e.count));
            chk("empty", 64'(bus.empty), 64'(mon_e.empty));
            chk("full", 64'(bus.full), 64'(mon_e.full));
            chk("overflow", 64'(bus.overflow), 64'(mon_e.ovf));
            chk("underflow", 64'(bus.underflow), 64'(mon_e.udf));
`ifdef STACK_HWM_EN
            chk("hwm", 64'(bus.hwm), 64'(mon_e.hwm));
`endif
        end
    end

    initial begin
        bit p;
        bit q;
        bit drained;
        rst = 1;
        bus.push = 0;
        bus.pop = 0;
        bus.din = '0;
        bus.clr_err = 0;
        op(0, 0, 8'h00, 0, 1);
        op(1, 1, 8'h5A, 0, 1);
        op(0, 1, 8'h00, 0, 0);
        op(0, 0, 8'h00, 1, 0);
        op(1, 0, 8'h11, 0, 0);
        op(1, 0, 8'h22, 0, 0);
        op(1, 0, 8'h33, 0, 0);
        op(0, 1, 8'h00, 0, 0);
        op(0, 1, 8'h00, 0, 0);
        op(0, 1, 8'h00, 0, 0);
        op(1, 1, 8'h44, 0, 0);
        op(0, 1, 8'h00, 0, 0);
        op(1, 0, 8'h05, 0, 0);
        op(1, 0, 8'h07, 0, 0);
        op(1, 1, 8'h09, 0, 0);
        for (int i = 0; i < 14; i++) op(1, 0, W'(8'h60 + i), 0, 0);
        op(1, 1, 8'h3C, 0, 0);
        op(1, 0, 8'hAA, 0, 0);
        op(1, 0, 8'hAB, 1, 0);
        op(0, 0, 8'h00, 1, 0);
        op(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) op(1, 0, W'(i + 1), 0, 0);
        op(1, 0, 8'hEE, 0, 1);
        for (int i = 0; i < 6; i++) op(1, 0, W'(8'hC0 + i), 0, 0);
        for (int i = 0; i < 4; i++) op(0, 1, 8'h00, 0, 0);
        op(1, 0, 8'hD0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            p = $urandom_range(0, 99) < (((i / 100) % 2) != 0 ? 70 : 30);
            q = $urandom_range(0, 99) < (((i / 100) % 2) != 0 ? 30 : 70);
            op(p, q, W'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        bus.push = 0;
        bus.pop = 0;
        bus.clr_err = 0;
        rst = 0;
        drained = 0;
        for (int k = 0; k < 10; k++) begin
            if (exp_q.size() == 0) begin
                drained = 1;
                break;
            end
            @(posedge clk);
            #2;
        end
        if (!drained) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
